// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC and a direct-mapped one-word-per-line I-cache.
// Cache misses are refilled from mem_ctrl. Fetched words reach decode as registered pc/inst/valid.
module inst_fetch #(
  parameter int ADDR_LEN   = 32,
  parameter int INST_LEN   = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  output logic [ADDR_LEN-1:0] mc_if_addr,
  output logic                mc_if_request,
  input  logic [INST_LEN-1:0] mc_if_inst,
  input  logic                mc_if_enable,
  input  logic                jump_en,
  input  logic [ADDR_LEN-1:0] jump_target,
  input  logic                stall,
  output logic [ADDR_LEN-1:0] id_pc,
  output logic [INST_LEN-1:0] id_inst,
  output logic                id_valid
);

  localparam int LINES   = 1 << INDEX_BITS;
  localparam int TAG_LEN = ADDR_LEN - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t              state, state_next;
  logic [ADDR_LEN-1:0] pc, pc_next, id_pc_next;
  logic [INST_LEN-1:0] id_inst_next;
  logic                id_valid_next;
  logic                fill;

  logic [LINES-1:0]    line_valid;
  logic [TAG_LEN-1:0]  tag_mem  [LINES];
  logic [INST_LEN-1:0] data_mem [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_LEN-1:0]    tag;
  logic                  hit;

  assign index = pc[INDEX_BITS+1:2];
  assign tag   = pc[ADDR_LEN-1:INDEX_BITS+2];
  assign hit   = line_valid[index] && (tag_mem[index] == tag);

  // A redirect cancels the outstanding request in the very cycle it arrives.
  assign mc_if_request = (state == MISS) && !jump_en;
  assign mc_if_addr    = (state == MISS) ? pc : '0;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    id_pc_next    = id_pc;
    id_inst_next  = id_inst;
    id_valid_next = id_valid;
    fill          = 1'b0;
    if (jump_en) begin
      pc_next       = {jump_target[ADDR_LEN-1:2], 2'b00};
      state_next    = IDLE;
      id_valid_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!stall) begin
            if (hit) begin
              id_valid_next = 1'b1;
              id_pc_next    = pc;
              id_inst_next  = data_mem[index];
              pc_next       = pc + ADDR_LEN'(4);
            end else begin
              id_valid_next = 1'b0;
              state_next    = MISS;
            end
          end
        end
        MISS: begin
          // Under stall the refilled word only lands in the cache and is re-read as a hit later.
          if (mc_if_enable) begin
            fill       = 1'b1;
            state_next = IDLE;
            if (!stall) begin
              id_valid_next = 1'b1;
              id_pc_next    = pc;
              id_inst_next  = mc_if_inst;
              pc_next       = pc + ADDR_LEN'(4);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      id_pc      <= '0;
      id_inst    <= '0;
      id_valid   <= 1'b0;
      line_valid <= '0;
    end else if (rdy) begin
      state    <= state_next;
      pc       <= pc_next;
      id_pc    <= id_pc_next;
      id_inst  <= id_inst_next;
      id_valid <= id_valid_next;
      if (fill) line_valid[index] <= 1'b1;
    end
  end

  // Data and tag arrays are deliberately left unreset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= mc_if_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then random traffic,
// all continuously compared against an address-level fetch model.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] mc_if_addr;
  logic        mc_if_request;
  logic [31:0] mc_if_inst;
  logic        mc_if_enable;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        stall;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.ADDR_LEN(32), .INST_LEN(32), .INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mc_if_addr(mc_if_addr), .mc_if_request(mc_if_request),
    .mc_if_inst(mc_if_inst), .mc_if_enable(mc_if_enable),
    .jump_en(jump_en), .jump_target(jump_target), .stall(stall),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory contents seen by the fetch stage.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00100093;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // Model: the cache is a map from line number to the full word address it holds.
  logic [31:0] m_pc = '0, m_idpc = '0, m_idinst = '0;
  logic        m_miss = 1'b0, m_idv = 1'b0;
  logic [31:0] c_addr [int];
  logic [31:0] c_data [int];

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  task automatic deliver(input logic [31:0] a, input logic [31:0] w);
    m_idv    = 1'b1;
    m_idpc   = a;
    m_idinst = w;
    m_pc     = a + 32'd4;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0; m_miss = 1'b0; m_idv = 1'b0; m_idpc = '0; m_idinst = '0;
      c_addr.delete();
      c_data.delete();
    end else if (rdy) begin
      if (jump_en) begin
        m_pc   = jump_target & 32'hFFFFFFFC;
        m_miss = 1'b0;
        m_idv  = 1'b0;
      end else if (!m_miss) begin
        if (!stall) begin
          if (c_addr.exists(line_of(m_pc)) && c_addr[line_of(m_pc)] == m_pc)
            deliver(m_pc, c_data[line_of(m_pc)]);
          else begin
            m_idv  = 1'b0;
            m_miss = 1'b1;
          end
        end
      end else if (mc_if_enable) begin
        c_addr[line_of(m_pc)] = m_pc;
        c_data[line_of(m_pc)] = mc_if_inst;
        m_miss = 1'b0;
        if (!stall) deliver(m_pc, mc_if_inst);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput("id_valid", {31'b0, id_valid}, {31'b0, m_idv});
    checkOutput("id_pc", id_pc, m_idpc);
    checkOutput("id_inst", id_inst, m_idinst);
    checkOutput("mc_if_request", {31'b0, mc_if_request}, {31'b0, m_miss && !jump_en});
    checkOutput("mc_if_addr", mc_if_addr, m_miss ? m_pc : 32'h0);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic expectReq(input string name, input logic [31:0] addr);
    checkOutput({name, "_req"}, {31'b0, mc_if_request}, 32'd1);
    checkOutput({name, "_addr"}, mc_if_addr, addr);
  endtask

  task automatic expectId(input string name, input logic [31:0] pcv, input logic [31:0] inst);
    checkOutput({name, "_valid"}, {31'b0, id_valid}, 32'd1);
    checkOutput({name, "_pc"}, id_pc, pcv);
    checkOutput({name, "_inst"}, id_inst, inst);
  endtask

  task automatic jumpTo(input logic [31:0] tgt);
    jump_en = 1'b1; jump_target = tgt;
    tick();
    jump_en = 1'b0;
  endtask

  task automatic refill(input logic [31:0] w);
    mc_if_enable = 1'b1; mc_if_inst = w;
    tick();
    mc_if_enable = 1'b0;
  endtask

  int lat = 0, cnt = 0;

  task automatic applyStimulus;
    int r;
    rst   = ($urandom_range(0, 199) == 0);
    rdy   = ($urandom_range(0, 9) != 0);
    stall = ($urandom_range(0, 4) == 0);
    jump_en = ($urandom_range(0, 19) == 0);
    r = $urandom_range(0, 9);
    if (r == 0) jump_target = 32'hFFFFFFF8;
    else jump_target = ($urandom_range(0, 3) << 8) + $urandom_range(0, 63);
    if (m_miss) begin
      if (cnt >= lat) begin
        mc_if_enable = 1'b1; mc_if_inst = mem_word(m_pc);
        cnt = 0; lat = $urandom_range(0, 3);
      end else begin
        mc_if_enable = 1'b0; cnt++;
      end
    end else begin
      mc_if_enable = 1'b0; cnt = 0;
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; mc_if_inst = '0; mc_if_enable = 1'b0;
    jump_en = 1'b0; jump_target = '0; stall = 1'b0;
    tick(); tick();
    checkOutput("reset_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("reset_req", {31'b0, mc_if_request}, 32'd0);
    checkOutput("reset_addr", mc_if_addr, 32'h0);

    // Cold miss at 0, refill, then the next fetch requests 4.
    rst = 1'b0;
    tick();
    expectReq("t1_miss", 32'h0);
    refill(32'h00100093);
    expectId("t1_deliver", 32'h0, 32'h00100093);
    tick();
    expectReq("t1_next", 32'h4);

    // Redirect back to 0 hits without a request.
    jump_en = 1'b1; jump_target = 32'h0;
    #1 checkOutput("t2_jump_req", {31'b0, mc_if_request}, 32'd0);
    tick();
    jump_en = 1'b0;
    tick();
    expectId("t2_hit", 32'h0, 32'h00100093);

    // Jump during a MISS discards the coincident refill.
    jumpTo(32'h8);
    tick();
    expectReq("t3_miss8", 32'h8);
    jump_en = 1'b1; jump_target = 32'h200; mc_if_enable = 1'b1; mc_if_inst = 32'hDEADBEEF;
    tick();
    jump_en = 1'b0; mc_if_enable = 1'b0;
    tick();
    expectReq("t3_miss200", 32'h200);
    refill(mem_word(32'h200));
    jumpTo(32'h8);
    tick();
    expectReq("t3_line2_invalid", 32'h8);

    // Stall holds decode outputs; a refill under stall only fills the cache.
    refill(mem_word(32'h8));
    expectId("t4_deliver", 32'h8, mem_word(32'h8));
    stall = 1'b1;
    repeat (5) begin
      tick();
      expectId("t4_hold", 32'h8, mem_word(32'h8));
      checkOutput("t4_no_req", {31'b0, mc_if_request}, 32'd0);
    end
    stall = 1'b0;
    tick();
    expectReq("t4_missC", 32'hC);
    stall = 1'b1;
    refill(mem_word(32'hC));
    tick();
    checkOutput("t4_stall_fill_valid", {31'b0, id_valid}, 32'd0);
    checkOutput("t4_stall_fill_req", {31'b0, mc_if_request}, 32'd0);
    stall = 1'b0;
    tick();
    expectId("t4_rehit", 32'hC, mem_word(32'hC));

    // 0x100 evicts 0x0 from the shared line.
    jumpTo(32'h0);
    tick();
    expectReq("t5_miss0", 32'h0);
    refill(mem_word(32'h0));
    jumpTo(32'h100);
    tick();
    expectReq("t5_miss100", 32'h100);
    refill(mem_word(32'h100));
    jumpTo(32'h0);
    tick();
    expectReq("t5_evicted", 32'h0);
    refill(mem_word(32'h0));

    // rdy=0 freezes a pending MISS.
    tick();
    expectReq("t6_miss4", 32'h4);
    rdy = 1'b0;
    repeat (4) begin
      tick();
      expectReq("t6_frozen", 32'h4);
    end
    rdy = 1'b1;
    refill(mem_word(32'h4));
    expectId("t6_done", 32'h4, mem_word(32'h4));

    repeat (4000) begin
      applyStimulus();
      tick();
    end
    rst = 1'b0; rdy = 1'b1; jump_en = 1'b0; stall = 1'b0; mc_if_enable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
